uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Second-generation UART transmitter with a built-in TX FIFO and valid/ready byte input.
//  Runtime divisor, parity mode and stop-bit count; parametrised character width and FIFO depth.
//  Sits between a host byte source and the serial pin; sends frames back-to-back while data is queued.
// PARAMETERS
//  DATA_W      8   character bits per frame, legal 5..9
//  FIFO_DEPTH  16  TX FIFO entries, power of two >= 2
//  DIV_W       16  width of baud_div
// PORTS
//  clk          in   1                        system clock, all logic on rising edge
//  rst          in   1                        synchronous, active-high reset
//  baud_div     in   DIV_W                    clocks per bit; values 0 and 1 are treated as 2
//  parity_mode  in   2                        00 none, 01 even, 10 odd, 11 mark (constant 1)
//  stop2        in   1                        0 = one stop bit, 1 = two stop bits
//  tx_en        in   1                        1 = may start new frames; 0 = finish current frame, then hold
//  s_valid      in   1                        input byte valid
//  s_ready      out  1                        FIFO can accept (= !full)
//  s_data       in   DATA_W                   character to send, LSB transmitted first
//  tx_serial    out  1                        serial line, idle high
//  tx_active    out  1                        high from first start-bit cycle to last stop-bit cycle
//  tx_done      out  1                        one-cycle pulse per completed frame
//  fifo_level   out  $clog2(FIFO_DEPTH+1)     entries currently queued
// BEHAVIOUR
//  Reset: tx_serial=1, tx_active=0, tx_done=0, fifo_level=0, s_ready=1.
//   FIFO flushed; FSM to IDLE; bit counter and divider counter cleared.
//   Reset mid-frame aborts the frame; tx_serial is 1 from the next cycle.
//  Outputs tx_serial, tx_active and tx_done are registered.
//  FIFO:
//   - Push on s_valid & s_ready.
//   - Pop only by the FSM at frame start.
//   - No fall-through: a byte pushed at edge k is first poppable at edge k+1.
//   - Full: s_ready=0; a push is refused even if a pop occurs the same cycle.
//   - Push and pop in the same cycle (not full): level unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  FSM states:
//   - IDLE: tx_serial=1. At an edge with level>0 and tx_en=1: pop, latch data, baud_div (clamped),
//     parity_mode and stop2, and go to START. Config changes mid-frame have no effect.
//   - START: tx_serial=0 for exactly div clocks, then DATA.
//   - DATA: DATA_W bits, LSB first, each exactly div clocks. Then PARITY if mode!=00, else STOP.
//   - PARITY: one bit for div clocks.
//     Even: bit = XOR of the data bits. Odd: bit = inverted XOR. Mark: bit = 1.
//   - STOP: tx_serial=1 for div clocks, or 2*div clocks when stop2=1.
//  End of the last stop clock:
//   - tx_done=1 for the following cycle.
//   - If level>0 and tx_en=1: pop and go directly to START, with no idle gap (tx_serial falls that same cycle).
//   - Otherwise go to IDLE.
//  Latency: a byte accepted at edge k into an empty, idle block gives tx_serial=0 from the cycle after edge k+1.
//  Frame length in clocks = (1 + DATA_W + P + S) * div, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
//  tx_en falling mid-frame: the current frame completes normally; no further pops.
//  Divider counter width is DIV_W and never wraps (count < div-1, then clear).
// TESTING
//  1. div=4, 8N1, push 0x55 -> line: 0,1,0,1,0,1,0,1,0,1, each bit 4 clk (40 clk total); one tx_done pulse.
//  2. div=3, even parity, 0x07 -> parity bit 1. Odd parity, 0x07 -> parity bit 0. Mark -> 1.
//     With stop2=1, the stop level lasts 6 clk.
//  3. tx_en=0, hold s_valid with 20 bytes -> s_ready falls after 16th accept, fifo_level=16, line stays 1.
//     Then tx_en=1 -> 16 frames back-to-back, no idle cycle between frames.
//     16 tx_done pulses; fifo_level decrements at each frame start.
//  4. Change baud_div 4->8 mid-frame -> current frame keeps 4 clk/bit; next frame uses 8.
//     baud_div=0 -> 2 clk/bit.
//  5. Assert rst during data bit 3 with 5 bytes queued -> next cycle tx_serial=1, tx_active=0, fifo_level=0;
//     no tx_done pulse.
//  6. DATA_W=7, FIFO_DEPTH=4, 7E2, div=2, push 0x41 -> 22-clk frame with parity bit 0;
//     5th push refused while full.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal TX FIFO and a valid/ready byte input.
// Runtime divisor, parity and stop-bit count are latched per frame at pop time.
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIV_W-1:0]                   baud_div,
  input  logic [1:0]                         parity_mode,
  input  logic                               stop2,
  input  logic                               tx_en,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [DATA_W-1:0]                  s_data,
  output logic                               tx_serial,
  output logic                               tx_active,
  output logic                               tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_ready;

  logic [2:0]        r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [1:0]        r_pmode;
  logic              r_stop2;
  logic              r_tx;
  logic              r_active;
  logic              r_done;

  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [DATA_W-1:0] w_rd_data;
  logic [DIV_W-1:0]  w_div_eff;
  logic              w_par_new;
  logic              w_bit_end;
  logic              w_can_start;

  logic [2:0]        w_state_nxt;
  logic [DIV_W-1:0]  w_div_cnt_nxt;
  logic [BIT_W-1:0]  w_bit_cnt_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_tx_nxt;
  logic              w_active_nxt;
  logic              w_done_nxt;

  assign s_ready    = r_ready;
  assign fifo_level = r_level;
  assign tx_serial  = r_tx;
  assign tx_active  = r_active;
  assign tx_done    = r_done;

  assign w_push      = s_valid & r_ready;
  assign w_pop       = w_load;
  assign w_rd_data   = r_mem[r_rd_ptr];
  assign w_div_eff   = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign w_bit_end   = (r_div_cnt == r_div - DIV_W'(1));
  assign w_can_start = (r_level != '0) && tx_en;
  assign w_par_new   = (parity_mode == 2'b01) ? ^w_rd_data :
                       (parity_mode == 2'b10) ? ~^w_rd_data : 1'b1;

  // FIFO storage; flushing is done through the pointers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_W'(FIFO_DEPTH));
    end
  end

  // Frame sequencing; next line level is computed here so tx_serial stays registered
  always_comb begin
    w_state_nxt   = r_state;
    w_div_cnt_nxt = r_div_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_active_nxt  = r_active;
    w_done_nxt    = 1'b0;
    w_load        = 1'b0;

    if (r_state != S_IDLE) begin
      w_div_cnt_nxt = w_bit_end ? '0 : r_div_cnt + DIV_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_tx_nxt     = 1'b1;
        w_active_nxt = 1'b0;
        w_load       = w_can_start;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_tx_nxt      = r_shift[0];
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
            w_bit_cnt_nxt = '0;
            if (r_pmode != 2'b00) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            w_shift_nxt   = r_shift >> 1;
            w_tx_nxt      = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt   = S_STOP;
          w_tx_nxt      = 1'b1;
          w_bit_cnt_nxt = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && (r_bit_cnt == '0)) begin
            w_bit_cnt_nxt = BIT_W'(1);
          end else begin
            w_done_nxt = 1'b1;
            if (w_can_start) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt  = S_IDLE;
              w_tx_nxt     = 1'b1;
              w_active_nxt = 1'b0;
            end
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_tx_nxt     = 1'b1;
        w_active_nxt = 1'b0;
      end
    endcase

    // Frame start: line falls on the same edge that pops the byte
    if (w_load) begin
      w_state_nxt   = S_START;
      w_div_cnt_nxt = '0;
      w_bit_cnt_nxt = '0;
      w_shift_nxt   = w_rd_data;
      w_tx_nxt      = 1'b0;
      w_active_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_div     <= DIV_W'(2);
      r_par     <= 1'b0;
      r_pmode   <= 2'b00;
      r_stop2   <= 1'b0;
      r_tx      <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_active  <= w_active_nxt;
      r_done    <= w_done_nxt;
      if (w_load) begin
        r_div   <= w_div_eff;
        r_par   <= w_par_new;
        r_pmode <= parity_mode;
        r_stop2 <= stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default 8-bit/16-deep instance plus a 7-bit/4-deep instance.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        tx_en, s_valid, s_ready;
  logic [7:0]  s_data;
  logic        tx_serial, tx_active, tx_done;
  logic [4:0]  fifo_level;

  logic        tx_en2, s_valid2, s_ready2;
  logic [6:0]  s_data2;
  logic        tx_serial2, tx_active2, tx_done2;
  logic [2:0]  fifo_level2;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode), .stop2(stop2),
    .tx_en(tx_en), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx_serial(tx_serial), .tx_active(tx_active), .tx_done(tx_done), .fifo_level(fifo_level)
  );

  uart_tx_fifo #(.DATA_W(7), .FIFO_DEPTH(4), .DIV_W(16)) dut2 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode), .stop2(stop2),
    .tx_en(tx_en2), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .tx_serial(tx_serial2), .tx_active(tx_active2), .tx_done(tx_done2), .fifo_level(fifo_level2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? tx_serial2 : tx_serial;
  endfunction

  function automatic logic active_of(input bit sel);
    return sel ? tx_active2 : tx_active;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? tx_done2 : tx_done;
  endfunction

  // Drive one byte for one cycle; called and returns on a falling edge
  task automatic push1(input bit sel, input logic [8:0] d);
    if (sel) begin s_valid2 = 1'b1; s_data2 = d[6:0]; end
    else     begin s_valid  = 1'b1; s_data  = d[7:0]; end
    @(negedge clk);
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
  endtask

  // Entered at the first start-bit cycle; returns one cycle after the last stop cycle
  task automatic frame_check(input bit sel, input logic [8:0] d, input int n, input int div,
                             input logic [1:0] pm, input bit s2);
    logic [15:0] fb;
    logic [8:0]  m;
    logic        par;
    int          nb;
    bit          in_frame_ok;
    m   = d & ((9'd1 << n) - 9'd1);
    par = (pm == 2'b01) ? ^m : (pm == 2'b10) ? ~^m : 1'b1;
    fb  = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < n; i++) fb[1 + i] = m[i];
    nb = 1 + n;
    if (pm != 2'b00) begin fb[nb] = par; nb++; end
    nb += s2 ? 2 : 1;
    in_frame_ok = 1'b1;
    for (int c = 0; c < nb * div; c++) begin
      check($sformatf("line_bit%0d_clk%0d", c / div, c % div), line_of(sel), fb[c / div]);
      if (c > 0 && (active_of(sel) !== 1'b1 || done_of(sel) !== 1'b0)) in_frame_ok = 1'b0;
      @(negedge clk);
    end
    check("active_nodone_in_frame", in_frame_ok, 1'b1);
    check("tx_done_pulse", done_of(sel), 1'b1);
  endtask

  task automatic send(input bit sel, input logic [8:0] d, input int n, input int div,
                      input logic [1:0] pm, input bit s2);
    push1(sel, d);
    @(negedge clk);
    check("start_latency", line_of(sel), 1'b0);
    frame_check(sel, d, n, div, pm, s2);
    @(negedge clk);
  endtask

  initial begin
    bit line_hi;
    bit saw_done;
    rst = 1'b1; baud_div = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
    tx_en = 1'b1; s_valid = 1'b0; s_data = '0;
    tx_en2 = 1'b0; s_valid2 = 1'b0; s_data2 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_serial", tx_serial, 1'b1);
    check("rst_tx_active", tx_active, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_tx_serial2", tx_serial2, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // 8N1, div 4, 0x55: latency then 40-clock frame
    push1(1'b0, 9'h55);
    check("lat_line_still_idle", tx_serial, 1'b1);
    check("lat_level_one", fifo_level, 1);
    @(negedge clk);
    check("lat_line_low", tx_serial, 1'b0);
    check("lat_level_zero", fifo_level, 0);
    frame_check(1'b0, 9'h55, 8, 4, 2'b00, 1'b0);
    check("idle_after_frame", tx_active, 1'b0);
    @(negedge clk);
    check("done_one_cycle", tx_done, 1'b0);

    // Parity modes at div 3 on 0x07, then two stop bits
    baud_div = 16'd3;
    parity_mode = 2'b01; send(1'b0, 9'h07, 8, 3, 2'b01, 1'b0);
    parity_mode = 2'b10; send(1'b0, 9'h07, 8, 3, 2'b10, 1'b0);
    parity_mode = 2'b11; send(1'b0, 9'h07, 8, 3, 2'b11, 1'b0);
    parity_mode = 2'b01; stop2 = 1'b1;
    send(1'b0, 9'h07, 8, 3, 2'b01, 1'b1);

    // Fill while disabled, then drain back-to-back
    baud_div = 16'd2; parity_mode = 2'b00; stop2 = 1'b0; tx_en = 1'b0;
    line_hi = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h10 + i);
      @(negedge clk);
      if (tx_serial !== 1'b1) line_hi = 1'b0;
      if (i == 14) check("ready_before_full", s_ready, 1'b1);
      if (i == 15) begin
        check("full_ready_low", s_ready, 1'b0);
        check("full_level_16", fifo_level, 16);
      end
    end
    s_valid = 1'b0;
    check("held_line_high", line_hi, 1'b1);
    check("held_level_16", fifo_level, 16);
    tx_en = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 16; f++) begin
      check($sformatf("drain_level_f%0d", f), fifo_level, 15 - f);
      frame_check(1'b0, 9'(9'h10 + f), 8, 2, 2'b00, 1'b0);
    end
    check("drain_idle", tx_active, 1'b0);
    check("drain_empty", fifo_level, 0);
    @(negedge clk);

    // Divisor change mid-frame, then divisor 0 clamps to 2
    tx_en = 1'b0; baud_div = 16'd4;
    push1(1'b0, 9'h0A3);
    push1(1'b0, 9'h03C);
    tx_en = 1'b1;
    @(negedge clk);
    baud_div = 16'd8;
    frame_check(1'b0, 9'h0A3, 8, 4, 2'b00, 1'b0);
    frame_check(1'b0, 9'h03C, 8, 8, 2'b00, 1'b0);
    @(negedge clk);
    baud_div = 16'd0;
    send(1'b0, 9'h05A, 8, 2, 2'b00, 1'b0);

    // Reset during data bit 3 with bytes queued
    tx_en = 1'b0; baud_div = 16'd4;
    for (int i = 0; i < 6; i++) push1(1'b0, 9'(9'h0C0 + i));
    tx_en = 1'b1;
    @(negedge clk);
    check("pre_rst_level", fifo_level, 5);
    repeat (17) @(negedge clk);
    check("pre_rst_bit3_low", tx_serial, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_serial", tx_serial, 1'b1);
    check("mid_rst_tx_active", tx_active, 1'b0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", s_ready, 1'b1);
    check("mid_rst_done", tx_done, 1'b0);
    rst = 1'b0;
    saw_done = 1'b0; line_hi = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx_done !== 1'b0) saw_done = 1'b1;
      if (tx_serial !== 1'b1) line_hi = 1'b0;
    end
    check("post_rst_no_done", saw_done, 1'b0);
    check("post_rst_line_idle", line_hi, 1'b1);

    // 7E2, div 2, depth 4: 0x41 gives 22-clock frame, parity 0
    stop2 = 1'b1; parity_mode = 2'b01; baud_div = 16'd2; tx_en2 = 1'b1;
    push1(1'b1, 9'h041);
    @(negedge clk);
    check("w7_start", tx_serial2, 1'b0);
    frame_check(1'b1, 9'h041, 7, 2, 2'b01, 1'b1);
    @(negedge clk);
    tx_en2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid2 = 1'b1;
      s_data2  = 7'(i + 1);
      @(negedge clk);
      if (i == 3) begin
        check("w7_full_ready", s_ready2, 1'b0);
        check("w7_full_level", fifo_level2, 4);
      end
    end
    s_valid2 = 1'b0;
    check("w7_fifth_refused", fifo_level2, 4);
    tx_en2 = 1'b1;
    @(negedge clk);
    check("w7_level_after_pop", fifo_level2, 3);
    frame_check(1'b1, 9'h001, 7, 2, 2'b01, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
